imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [31:0]       o_wdata;
  logic              o_cpu_hold;
  logic              o_done;
  logic              o_error;

  // Loader side: consumes received bytes, drives RAM writes and status.
  modport master (
    input  i_rx_valid, i_rx_data,
    output o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_error
  );

  // Environment side: UART receiver, instruction RAM and top-level status.
  modport slave (
    output i_rx_valid, i_rx_data,
    input  o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction store writer: parses framed UART bytes (sync, length, data,
// XOR checksum), packs big-endian 32-bit words and writes them to the
// instruction RAM while holding the CPU.
module imem_loader #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input logic           i_clk,
  input logic           i_rst_n,
  imem_loader_if.master bus
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  // Only the first three bytes of a word need storing; the fourth is
  // taken straight from the input when the write is issued.
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              in_frame;
  logic              timeout;
  logic [15:0]       len;

  // Next-state and registered-output computation for the frame parser.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    chk_d    = chk_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    error_d  = error_q;

    in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA)   || (state_q == S_CHECK);
    // Counter holds completed idle cycles; the timeout fires on the edge
    // where it would reach TIMEOUT_CYCLES, and beats any byte that cycle.
    timeout  = in_frame && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
    tcnt_d   = (in_frame && !bus.i_rx_valid) ? tcnt_q + 32'd1 : '0;
    len      = {len_hi_q, bus.i_rx_data};

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    if (timeout) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end else if (bus.i_rx_valid) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.i_rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            hold_d  = 1'b1;
            error_d = 1'b0;
            chk_d   = '0;
            addr_d  = '0;
            bcnt_d  = '0;
          end
        end
        S_LEN_HI: begin
          len_hi_d = bus.i_rx_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if ((len == 16'd0) || (32'(len) > CAPACITY)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            last_d  = ADDR_W'(len - 16'd1);
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          asm_d  = {asm_q[15:0], bus.i_rx_data};
          chk_d  = chk_q ^ bus.i_rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {asm_q, bus.i_rx_data};
            addr_d  = addr_q + ADDR_W'(1);
            if (addr_q == last_q) begin
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (bus.i_rx_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      chk_q    <= '0;
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      chk_q    <= chk_d;
      tcnt_q   <= tcnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.o_we       = we_q;
  assign bus.o_waddr    = waddr_q;
  assign bus.o_wdata    = wdata_q;
  assign bus.o_cpu_hold = hold_q;
  assign bus.o_done     = done_q;
  assign bus.o_error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TMO    = 50;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Write/done monitor, sampled on the falling edge.
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];
  int                cyc      = 0;
  int                done_cnt = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (bus.o_done === 1'b1) done_cnt++;
    if (bus.o_we === 1'b1) begin
      wa_q.push_back(bus.o_waddr);
      wd_q.push_back(bus.o_wdata);
      wc_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] word_of(input int unsigned i);
    logic [8:0] a;
    a = i[8:0];
    return {a[7:0], ~a[7:0], 8'h5A, 7'd0, a[8]};
  endfunction

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge i_clk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_we"},    32'(bus.o_we),       32'd0);
    check({p, "_waddr"}, 32'(bus.o_waddr),    32'd0);
    check({p, "_wdata"}, bus.o_wdata,         32'd0);
    check({p, "_hold"},  32'(bus.o_cpu_hold), 32'd0);
    check({p, "_done"},  32'(bus.o_done),     32'd0);
    check({p, "_error"}, 32'(bus.o_error),    32'd0);
  endtask

  // Two-word frame body: 20100000, 20050000; XOR of its data bytes is 8'h15.
  task automatic send_two_words(input string p);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h10); send(8'h00); send(8'h00);
    check({p, "_we0"},    32'(bus.o_we),    32'd1);
    check({p, "_waddr0"}, 32'(bus.o_waddr), 32'd0);
    check({p, "_wdata0"}, bus.o_wdata,      32'h20100000);
    send(8'h20); send(8'h05); send(8'h00); send(8'h00);
    check({p, "_we1"},    32'(bus.o_we),    32'd1);
    check({p, "_waddr1"}, 32'(bus.o_waddr), 32'd1);
    check({p, "_wdata1"}, bus.o_wdata,      32'h20050000);
  endtask

  initial begin
    logic [7:0]  chk;
    logic [31:0] w;
    int          bad_data;
    int          bad_gap;

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    i_rst_n        = 1'b0;
    idle(3);
    check_reset_outputs("por");
    i_rst_n = 1'b1;
    idle(2);

    // Nominal load.
    clear_mon();
    send(8'hA5);
    check("nom_hold_rise", 32'(bus.o_cpu_hold), 32'd1);
    send_two_words("nom");
    send(8'h15);
    check("nom_done",  32'(bus.o_done),     32'd1);
    check("nom_hold",  32'(bus.o_cpu_hold), 32'd0);
    check("nom_error", 32'(bus.o_error),    32'd0);
    idle(1);
    check("nom_done_pulse", 32'(bus.o_done), 32'd0);
    idle(1);
    check("nom_writes",   32'(wa_q.size()), 32'd2);
    check("nom_done_cnt", 32'(done_cnt),    32'd1);

    // Bad checksum, then recovery frame.
    clear_mon();
    send(8'hA5);
    send_two_words("badck");
    send(8'hFF);
    check("badck_error", 32'(bus.o_error),    32'd1);
    check("badck_hold",  32'(bus.o_cpu_hold), 32'd1);
    check("badck_done",  32'(bus.o_done),     32'd0);
    idle(2);
    check("badck_writes",   32'(wa_q.size()), 32'd2);
    check("badck_done_cnt", 32'(done_cnt),    32'd0);
    send(8'hA5);
    check("recov_error_clr", 32'(bus.o_error), 32'd0);
    send_two_words("recov");
    send(8'h15);
    check("recov_done", 32'(bus.o_done),     32'd1);
    check("recov_hold", 32'(bus.o_cpu_hold), 32'd0);
    idle(2);

    // Illegal lengths: 0 and 513.
    clear_mon();
    send(8'hA5); send(8'h00); send(8'h00);
    check("len0_error", 32'(bus.o_error), 32'd1);
    check("len0_we",    32'(bus.o_we),    32'd0);
    send(8'hA5);
    check("len513_clr", 32'(bus.o_error), 32'd0);
    send(8'h02); send(8'h01);
    check("len513_error", 32'(bus.o_error),    32'd1);
    check("len513_hold",  32'(bus.o_cpu_hold), 32'd1);
    idle(2);
    check("len_writes", 32'(wa_q.size()), 32'd0);

    // Timeout 50 cycles after the last byte; stray bytes afterwards ignored.
    clear_mon();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    idle(TMO - 1);
    check("tmo_early", 32'(bus.o_error), 32'd0);
    idle(1);
    check("tmo_fire", 32'(bus.o_error), 32'd1);
    send(8'h56); send(8'h78); send(8'h00); send(8'h00);
    idle(2);
    check("tmo_writes", 32'(wa_q.size()),    32'd0);
    check("tmo_hold",   32'(bus.o_cpu_hold), 32'd1);
    check("tmo_error",  32'(bus.o_error),    32'd1);

    // Full capacity, bytes on every cycle.
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h00);
    chk = 8'h00;
    for (int unsigned i = 0; i < 512; i++) begin
      w = word_of(i);
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
      chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    send(chk);
    check("full_done_now", 32'(bus.o_done), 32'd1);
    idle(2);
    check("full_writes", 32'(wa_q.size()), 32'd512);
    bad_data = 0;
    bad_gap  = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] != ADDR_W'(i) || wd_q[i] != word_of(i)) bad_data++;
      if (i > 0 && (wc_q[i] - wc_q[i-1]) != 4) bad_gap++;
    end
    check("full_data_errs", 32'(bad_data), 32'd0);
    check("full_gap_errs",  32'(bad_gap),  32'd0);
    check("full_done_cnt",  32'(done_cnt), 32'd1);
    check("full_error",     32'(bus.o_error),    32'd0);
    check("full_hold",      32'(bus.o_cpu_hold), 32'd0);

    // Reset after the 6th data byte, then a fresh one-word frame.
    clear_mon();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    check("mid_hold_before", 32'(bus.o_cpu_hold), 32'd1);
    i_rst_n = 1'b0;
    idle(1);
    i_rst_n = 1'b1;
    check_reset_outputs("mid");
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    check("post_we",    32'(bus.o_we),    32'd1);
    check("post_waddr", 32'(bus.o_waddr), 32'd0);
    check("post_wdata", bus.o_wdata,      32'hDEADBEEF);
    send(8'h22);
    check("post_done", 32'(bus.o_done),     32'd1);
    check("post_hold", 32'(bus.o_cpu_hold), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
